// File: rtl/fetch_queue_stage.sv
// fetch_queue_stage: RV32 fetch front end issuing in-order word requests, tagging them with
// their PCs and buffering responses for decode. Define FETCH_PERF_CNT_EN for perf counters.
module fetch_queue_stage #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        out_valid,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  input  logic        out_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_flushed
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [CW-1:0] outstanding, drop, count;
  logic [AW-1:0] tag_wr, tag_rd, q_wr, q_rd;
  logic [31:0]   tag_mem  [DEPTH];
  logic [31:0]   inst_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   head_inst, head_pc;

  logic          accept, resp, push, pop;
  logic [CW:0]   in_use;
  logic [CW-1:0] outstanding_next, drop_next, count_after_pop, count_next;
  logic [AW-1:0] q_rd_after_pop;
  logic [31:0]   tag_pc, head_inst_next, head_pc_next, fetch_pc_next;

  always_comb begin
    in_use          = {1'b0, outstanding} + {1'b0, count};
    imem_req_valid  = !reset && !halt && !redirect_valid && (in_use < DEPTH_W);
    imem_req_addr   = fetch_pc;
    out_valid       = (count != '0);
    out_inst        = head_inst;
    out_pc          = head_pc;

    accept          = imem_req_valid && imem_req_ready;
    // A response with nothing outstanding is illegal and simply ignored.
    resp            = imem_resp_valid && (outstanding != '0);
    push            = resp && (drop == '0) && !redirect_valid;
    pop             = out_valid && out_ready;
    tag_pc          = tag_mem[tag_rd];

    outstanding_next = outstanding + CW'(accept) - CW'(resp);
    count_after_pop  = count - CW'(pop);
    q_rd_after_pop   = q_rd + AW'(pop);

    drop_next      = drop - CW'(resp && (drop != '0));
    count_next     = count_after_pop + CW'(push);
    fetch_pc_next  = accept ? fetch_pc + 32'd4 : fetch_pc;
    head_inst_next = head_inst;
    head_pc_next   = head_pc;

    if (redirect_valid) begin
      // Everything still in flight becomes stale, including requests already being dropped.
      drop_next     = outstanding_next;
      count_next    = '0;
      fetch_pc_next = redirect_pc & 32'hFFFF_FFFC;
    end else if (count_after_pop != '0) begin
      head_inst_next = inst_mem[q_rd_after_pop];
      head_pc_next   = pc_mem[q_rd_after_pop];
    end else if (push) begin
      head_inst_next = imem_resp_data;
      head_pc_next   = tag_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      count       <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
      q_wr        <= '0;
      q_rd        <= '0;
      head_inst   <= '0;
      head_pc     <= '0;
    end else begin
      fetch_pc    <= fetch_pc_next;
      outstanding <= outstanding_next;
      drop        <= drop_next;
      count       <= count_next;
      tag_wr      <= tag_wr + AW'(accept);
      tag_rd      <= tag_rd + AW'(resp);
      q_wr        <= redirect_valid ? '0 : q_wr + AW'(push);
      q_rd        <= redirect_valid ? '0 : q_rd_after_pop;
      head_inst   <= head_inst_next;
      head_pc     <= head_pc_next;
    end
  end

  // Storage arrays carry no reset; occupancy is tracked by the pointers and counters.
  always_ff @(posedge clk) begin
    if (accept) tag_mem[tag_wr] <= fetch_pc;
    if (push) begin
      inst_mem[q_wr] <= imem_resp_data;
      pc_mem[q_wr]   <= tag_pc;
    end
  end

  always_ff @(posedge clk)
    if (!reset) assert (!(imem_resp_valid && (outstanding == '0)));

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
      perf_flushed <= '0;
    end else begin
      perf_fetched <= perf_fetched + 32'(pop);
      perf_stall   <= perf_stall + 32'(out_ready && !out_valid);
      perf_flushed <= perf_flushed + 32'(resp && !push)
                    + (redirect_valid ? 32'(count_after_pop) : 32'd0);
    end
  end
`endif
endmodule

// File: tb/tb_fetch_queue_stage.sv
// tb_fetch_queue_stage: randomized bench with a queue-based reference model of fetch_queue_stage
// and an in-order variable-latency instruction memory.
module tb_fetch_queue_stage;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1, imem_req_ready = 1'b0, imem_resp_valid = 1'b0;
  logic        out_ready = 1'b0, redirect_valid = 1'b0, halt = 1'b0;
  logic [31:0] imem_resp_data = '0, redirect_pc = '0;
  logic        imem_req_valid, out_valid;
  logic [31:0] imem_req_addr, out_inst, out_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_stall, perf_flushed;
`endif

  fetch_queue_stage #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data),
    .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc), .out_ready(out_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_stall(perf_stall), .perf_flushed(perf_flushed)
`endif
  );

  typedef struct packed { logic [31:0] pc; logic stale; } fl_t;
  typedef struct packed { logic [31:0] pc; logic [31:0] inst; } ent_t;
  typedef struct { int due; logic [31:0] data; } mr_t;

  int n_tests = 0, n_fail = 0;
  int cyc = 0, lat = 1, last_due = 0;
  logic [31:0] mask = '0;
  logic nxt_reset = 1'b1, nxt_ready = 1'b1, nxt_oready = 1'b1, nxt_redir = 1'b0, nxt_halt = 1'b0;
  logic [31:0] nxt_rpc = '0;

  logic [31:0] m_pc, last_inst, last_pc, m_fetched, m_stall, m_flushed;
  fl_t  inflight[$];
  ent_t fifo[$];
  mr_t  memq[$];

  logic exp_req_valid, exp_out_valid, chk_en = 1'b0;
  logic [31:0] exp_addr, exp_inst, exp_pc;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Advance the model across the clock edge using the inputs of the cycle just ending.
  task automatic model_update();
    fl_t f;
    mr_t r;
    int  d;
    if (reset) begin
      m_pc = RESET_PC; inflight.delete(); fifo.delete(); memq.delete();
      last_inst = '0; last_pc = '0; last_due = 0;
      m_fetched = '0; m_stall = '0; m_flushed = '0;
    end else begin
      if (fifo.size() != 0 && out_ready) begin
        void'(fifo.pop_front());
        m_fetched++;
      end
      if (fifo.size() == 0 && !exp_out_valid && out_ready) m_stall++;
      if (imem_resp_valid && inflight.size() != 0) begin
        f = inflight.pop_front();
        r = memq.pop_front();
        if (f.stale || redirect_valid) m_flushed++;
        else fifo.push_back({f.pc, imem_resp_data});
      end
      if (redirect_valid) begin
        m_flushed += fifo.size();
        fifo.delete();
        foreach (inflight[i]) inflight[i].stale = 1'b1;
        m_pc = {redirect_pc[31:2], 2'b00};
      end else if (exp_req_valid && imem_req_ready) begin
        inflight.push_back({m_pc, 1'b0});
        d = cyc + lat;
        if (d <= last_due) d = last_due + 1;
        memq.push_back('{due: d, data: m_pc ^ mask});
        last_due = d;
        m_pc += 32'd4;
      end
    end
  endtask

  task automatic drive();
    cyc++;
    reset = nxt_reset; imem_req_ready = nxt_ready; out_ready = nxt_oready;
    redirect_valid = nxt_redir; redirect_pc = nxt_rpc; halt = nxt_halt;
    imem_resp_valid = (memq.size() != 0) && (memq[0].due <= cyc);
    imem_resp_data  = imem_resp_valid ? memq[0].data : 32'hDEAD_BEEF;
    exp_req_valid = !reset && !halt && !redirect_valid && (inflight.size() + fifo.size() < DEPTH);
    exp_addr      = m_pc;
    exp_out_valid = (fifo.size() != 0);
    if (exp_out_valid) begin
      last_inst = fifo[0].inst;
      last_pc   = fifo[0].pc;
    end
    exp_inst = last_inst;
    exp_pc   = last_pc;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    drive();
    chk_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic reset_dut();
    nxt_reset = 1'b1;
    step();
    step();
    nxt_reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check32("imem_req_valid", 32'(imem_req_valid), 32'(exp_req_valid));
      check32("imem_req_addr", imem_req_addr, exp_addr);
      check32("out_valid", 32'(out_valid), 32'(exp_out_valid));
      check32("out_inst", out_inst, exp_inst);
      check32("out_pc", out_pc, exp_pc);
`ifdef FETCH_PERF_CNT_EN
      check32("perf_fetched", perf_fetched, m_fetched);
      check32("perf_stall", perf_stall, m_stall);
      check32("perf_flushed", perf_flushed, m_flushed);
`endif
    end
  end

  initial begin
    logic [31:0] wrap_addr [3];
    int pops;
    wrap_addr[0] = 32'hFFFF_FFF8; wrap_addr[1] = 32'hFFFF_FFFC; wrap_addr[2] = 32'h0000_0000;

    // Streaming with a 1-cycle memory that returns the address as data.
    lat = 1; mask = '0; nxt_ready = 1'b1; nxt_oready = 1'b1;
    reset_dut();
    check32("rst_out_valid", 32'(out_valid), 32'd0);
    check32("rst_out_inst", out_inst, 32'd0);
    check32("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check32("rst_req_addr", imem_req_addr, RESET_PC);
    step();
    check32("c0_req_valid", 32'(imem_req_valid), 32'd1);
    check32("c0_req_addr", imem_req_addr, 32'h0);
    step();
    check32("c1_out_valid", 32'(out_valid), 32'd0);
    step();
    check32("c2_out_valid", 32'(out_valid), 32'd1);
    check32("c2_out_pc", out_pc, 32'h0);
    step();
    check32("c3_out_pc", out_pc, 32'h4);
    check32("c3_out_inst", out_inst, 32'h4);
    repeat (6) step();

    // Decode stalled: FIFO fills to DEPTH and issue stops.
    nxt_oready = 1'b0;
    reset_dut();
    repeat (10) step();
    check32("full_req_valid", 32'(imem_req_valid), 32'd0);
    check32("full_out_valid", 32'(out_valid), 32'd1);
    nxt_oready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check32("drain_out_pc", out_pc, 32'(k * 4));
    end
    repeat (4) step();

    // Redirect with two requests in flight on a 3-cycle memory.
    lat = 3; mask = 32'h1357_0000;
    reset_dut();
    step();
    step();
    nxt_redir = 1'b1; nxt_rpc = 32'h0000_0100;
    step();
    check32("redir_req_valid", 32'(imem_req_valid), 32'd0);
    nxt_redir = 1'b0;
    step();
    check32("post_redir_out_valid", 32'(out_valid), 32'd0);
    check32("post_redir_addr", imem_req_addr, 32'h0000_0100);
    for (int i = 0; i < 20 && !out_valid; i++) step();
    check32("redir_first_valid", 32'(out_valid), 32'd1);
    check32("redir_first_pc", out_pc, 32'h0000_0100);
    check32("redir_first_inst", out_inst, 32'h1357_0100);
    step();

    // Misaligned redirect target.
    nxt_redir = 1'b1; nxt_rpc = 32'h0000_0203;
    step();
    nxt_redir = 1'b0;
    step();
    check32("align_addr", imem_req_addr, 32'h0000_0200);
    for (int i = 0; i < 20 && !out_valid; i++) step();
    check32("align_out_pc", out_pc, 32'h0000_0200);

    // Address wrap at the top of the 32-bit space.
    lat = 1; mask = '0;
    nxt_redir = 1'b1; nxt_rpc = 32'hFFFF_FFF8;
    step();
    nxt_redir = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      for (int i = 0; i < 20 && !imem_req_valid; i++) step();
      check32("wrap_addr", imem_req_addr, wrap_addr[k]);
    end
    repeat (6) step();

    // Halt with two outstanding requests.
    lat = 3;
    reset_dut();
    step();
    step();
    nxt_halt = 1'b1;
    pops = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (out_valid && out_ready) pops++;
    end
    check32("halt_pops", 32'(pops), 32'd2);
    check32("halt_out_valid", 32'(out_valid), 32'd0);
    check32("halt_req_valid", 32'(imem_req_valid), 32'd0);
`ifdef FETCH_PERF_CNT_EN
    check32("halt_perf_fetched", perf_fetched, 32'd2);
`endif
    nxt_halt = 1'b0;

    // Randomized traffic, including one reset in the middle of operation.
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) lat = int'($urandom_range(1, 4));
      mask       = $urandom;
      nxt_ready  = ($urandom_range(0, 3) != 0);
      nxt_oready = ($urandom_range(0, 3) != 0);
      nxt_redir  = ($urandom_range(0, 19) == 0);
      nxt_rpc    = $urandom;
      if ($urandom_range(0, 29) == 0) nxt_halt = !nxt_halt;
      nxt_reset  = (i == 1500);
      step();
    end
    nxt_reset = 1'b0; nxt_redir = 1'b0; nxt_halt = 1'b0;
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
